// File: rtl/jtglfgreat_adc.sv
// Serial 4-channel ADC0834-style converter, bit-banged by CPU writes of CS_n/CLK/DI.
// Define ADC_LSB_EN to append the LSB-first tail after the MSB-first result.
module jtglfgreat_adc #(
    parameter int unsigned AW     = 8,
    parameter int unsigned SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_cen,
    input  logic          wr,
    input  logic [2:0]    din,
    input  logic [AW-1:0] ana0,
    input  logic [AW-1:0] ana1,
    input  logic [AW-1:0] ana2,
    input  logic [AW-1:0] ana3,
    output logic          adc,
    output logic          sars
);

    localparam int unsigned CntMax = (AW > SETTLE) ? ((AW > 3) ? AW : 3)
                                                   : ((SETTLE > 3) ? SETTLE : 3);
    localparam int unsigned CW     = $clog2(CntMax + 1);

`ifdef ADC_LSB_EN
    typedef enum logic [2:0] {
        StIdle, StStart, StAddr, StSettle, StMsb, StLsb, StDone
    } state_t;
`else
    typedef enum logic [2:0] {
        StIdle, StStart, StAddr, StSettle, StMsb, StDone
    } state_t;
`endif

    state_t        state_q;
    logic [2:0]    pins_q;      // {CS_n, CLK, DI}
    logic [2:0]    pin_d;
    logic [1:0]    addr_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] sr_q;
`ifdef ADC_LSB_EN
    logic [AW-1:0] lsb_q;
`endif
    logic          adc_q, sars_q;

    logic          wr_en, rise, fall, cs_fall;
    logic [2:0]    addr;
    logic [AW-1:0] chan_a, chan_b, result;

    assign wr_en   = wr & cpu_cen;
    assign pin_d   = wr_en ? din : pins_q;
    assign rise    = pin_d[1] & ~pins_q[1];
    assign fall    = ~pin_d[1] & pins_q[1];
    assign cs_fall = ~pin_d[2] & pins_q[2];

    assign adc  = adc_q;
    assign sars = sars_q;

    // Result for the address completed by the current rise: {SGL, ODD, SEL}.
    always_comb begin
        addr   = {addr_q, pin_d[0]};
        chan_a = '0;
        chan_b = '0;
        result = '0;
        unique case ({addr[0], addr[1]})
            2'b00: begin chan_a = ana0; chan_b = ana1; end
            2'b01: begin chan_a = ana1; chan_b = ana0; end
            2'b10: begin chan_a = ana2; chan_b = ana3; end
            2'b11: begin chan_a = ana3; chan_b = ana2; end
            default: ;
        endcase
        if (addr[2]) begin
            result = chan_a;
        end else if (chan_a > chan_b) begin
            result = chan_a - chan_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pins_q  <= 3'b100;
            addr_q  <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
`ifdef ADC_LSB_EN
            lsb_q   <= '0;
`endif
            adc_q   <= 1'b1;
            sars_q  <= 1'b0;
        end else begin
            pins_q <= pin_d;
            if (pin_d[2]) begin
                // CS_n high overrides any clock edge in the same write.
                state_q <= StIdle;
                adc_q   <= 1'b1;
                sars_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cs_fall) state_q <= StStart;
                    end
                    StStart: begin
                        if (rise && pin_d[0]) begin
                            state_q <= StAddr;
                            cnt_q   <= '0;
                        end
                    end
                    StAddr: begin
                        if (rise) begin
                            addr_q <= {addr_q[0], pin_d[0]};
                            if (cnt_q == CW'(2)) begin
                                sr_q    <= result;
`ifdef ADC_LSB_EN
                                lsb_q   <= result >> 1;
`endif
                                sars_q  <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= (SETTLE == 0) ? StMsb : StSettle;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    StSettle: begin
                        if (fall) begin
                            if (cnt_q == CW'(SETTLE - 1)) begin
                                cnt_q   <= '0;
                                state_q <= StMsb;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    StMsb: begin
                        if (fall) begin
                            if (cnt_q == CW'(AW)) begin
`ifdef ADC_LSB_EN
                                if (AW > 1) begin
                                    adc_q   <= lsb_q[0];
                                    lsb_q   <= lsb_q >> 1;
                                    cnt_q   <= CW'(1);
                                    state_q <= StLsb;
                                end else begin
                                    adc_q   <= 1'b0;
                                    sars_q  <= 1'b0;
                                    state_q <= StDone;
                                end
`else
                                adc_q   <= 1'b0;
                                sars_q  <= 1'b0;
                                state_q <= StDone;
`endif
                            end else begin
                                adc_q <= sr_q[AW-1];
                                sr_q  <= sr_q << 1;
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
`ifdef ADC_LSB_EN
                    StLsb: begin
                        if (fall) begin
                            if (cnt_q == CW'(AW - 1)) begin
                                adc_q   <= 1'b0;
                                sars_q  <= 1'b0;
                                state_q <= StDone;
                            end else begin
                                adc_q <= lsb_q[0];
                                lsb_q <= lsb_q >> 1;
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
`endif
                    StDone: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtglfgreat_adc.sv
// Scoreboard bench for jtglfgreat_adc: a protocol-level model queues expected adc/sars per write.
module tb_jtglfgreat_adc;
    localparam int AW     = 8;
    localparam int SETTLE = 1;
    localparam int FULL   = SETTLE + 2 * AW + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_cen = 1'b0;
    logic          wr = 1'b0;
    logic [2:0]    din = 3'b100;
    logic [AW-1:0] ana [4];
    logic          adc, sars;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q [$];
    bit         drv_act = 1'b0;

    // Model state: protocol phase, pin history, and the queue of per-fall outputs.
    int         m_mode;   // 0 idle, 1 wait start, 2 address, 3 converting
    int         m_nb;
    int         m_addr;
    logic       m_cs, m_sclk, m_adc, m_sars;
    logic [1:0] m_fq [$];

    jtglfgreat_adc #(.AW(AW), .SETTLE(SETTLE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cpu_cen (cpu_cen),
        .wr      (wr),
        .din     (din),
        .ana0    (ana[0]),
        .ana1    (ana[1]),
        .ana2    (ana[2]),
        .ana3    (ana[3]),
        .adc     (adc),
        .sars    (sars)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_mode = 0; m_nb = 0; m_addr = 0;
        m_cs = 1'b1; m_sclk = 1'b0; m_adc = 1'b1; m_sars = 1'b0;
        m_fq.delete();
    endtask

    function automatic int conv_value(input int a);
        int sgl, odd, sel, x, y;
        sgl = (a >> 2) & 1;
        odd = (a >> 1) & 1;
        sel = a & 1;
        x = int'(ana[sel * 2 + odd]);
        y = int'(ana[sel * 2 + 1 - odd]);
        if (sgl == 1) return x;
        return (x > y) ? x - y : 0;
    endfunction

    task automatic model_step(input logic cen, input logic cs, input logic sclk, input logic di);
        logic rise, fall, csf;
        int   r;
        if (!cen) return;
        rise = sclk & ~m_sclk;
        fall = ~sclk & m_sclk;
        csf  = ~cs & m_cs;
        m_cs = cs;
        m_sclk = sclk;
        if (cs) begin
            m_mode = 0; m_adc = 1'b1; m_sars = 1'b0;
            m_fq.delete();
            return;
        end
        case (m_mode)
            0: if (csf) m_mode = 1;
            1: if (rise && di) begin m_mode = 2; m_nb = 0; m_addr = 0; end
            2: if (rise) begin
                m_addr = m_addr * 2 + int'(di);
                m_nb++;
                if (m_nb == 3) begin
                    r = conv_value(m_addr);
                    m_fq.delete();
                    for (int i = 0; i < SETTLE; i++) m_fq.push_back(2'b11);
                    for (int i = AW - 1; i >= 0; i--) m_fq.push_back({r[i], 1'b1});
`ifdef ADC_LSB_EN
                    for (int i = 1; i < AW; i++) m_fq.push_back({r[i], 1'b1});
`endif
                    m_fq.push_back(2'b00);
                    m_sars = 1'b1;
                    m_mode = 3;
                end
            end
            3: if (fall && m_fq.size() > 0) {m_adc, m_sars} = m_fq.pop_front();
            default: ;
        endcase
    endtask

    task automatic pin(input logic cs, input logic sclk, input logic di,
                       input logic cen = 1'b1);
        @(negedge clk);
        wr = 1'b1;
        cpu_cen = cen;
        din = {cs, sclk, di};
        drv_act = 1'b1;
        model_step(cen, cs, sclk, di);
        exp_q.push_back({m_adc, m_sars});
        @(negedge clk);
        wr = 1'b0;
        cpu_cen = 1'b0;
        drv_act = 1'b0;
    endtask

    task automatic clk_bit(input logic di);
        if ($urandom_range(0, 5) == 0)
            pin(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        pin(1'b0, 1'b1, di);
        pin(1'b0, 1'b0, di);
    endtask

    task automatic conv(input logic sgl, input logic odd, input logic sel,
                        input int nfalls, input int pre_zero);
        pin(1'b1, 1'b0, 1'b0);
        pin(1'b0, 1'b0, 1'b0);
        repeat (pre_zero) clk_bit(1'b0);
        clk_bit(1'b1);
        clk_bit(sgl);
        clk_bit(odd);
        clk_bit(sel);
        repeat (nfalls) clk_bit(1'($urandom));
        pin(1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    always @(posedge clk) begin
        bit         act;
        logic [1:0] e;
        act = drv_act;
        #1;
        if (act) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: output with no queued expectation");
            end else begin
                e = exp_q.pop_front();
                if ({adc, sars} !== e) begin
                    errors++;
                    $display("FAIL out: got adc=%b sars=%b required adc=%b sars=%b",
                             adc, sars, e[1], e[0]);
                end
            end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < 4; i++) ana[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        check_bit("reset_adc", adc, 1'b1);
        check_bit("reset_sars", sars, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a conversion.
        ana[2] = 8'hA5;
        pin(1'b1, 1'b0, 1'b0);
        pin(1'b0, 1'b0, 1'b0);
        clk_bit(1'b1); clk_bit(1'b1); clk_bit(1'b0); clk_bit(1'b1); clk_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_bit("midreset_adc", adc, 1'b1);
        check_bit("midreset_sars", sars, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Single-ended channel 2, then differential pairs including saturation.
        conv(1'b1, 1'b0, 1'b1, FULL, 0);
        ana[0] = 8'h40; ana[1] = 8'h10;
        conv(1'b0, 1'b0, 1'b0, FULL, 0);
        conv(1'b0, 1'b1, 1'b0, FULL, 0);

        // Abort after the 4th MSB bit, then restart on a full-scale channel.
        ana[3] = 8'hFF;
        conv(1'b1, 1'b0, 1'b1, SETTLE - 1 + 4, 0);
        conv(1'b1, 1'b1, 1'b1, FULL, 0);

        // Missing start bit: zero-DI rises are skipped.
        conv(1'b1, 1'b0, 1'b1, FULL, 3);

        // Disabled writes and clock toggles with CS_n high.
        pin(1'b0, 1'b1, 1'b1, 1'b0);
        pin(1'b1, 1'b1, 1'b1);
        pin(1'b1, 1'b0, 1'b1);
        pin(1'b0, 1'b0, 1'b0, 1'b0);
        pin(1'b1, 1'b1, 1'b0);

        // Analog inputs change mid-shift: model sampled once at address end.
        ana[1] = 8'h3C;
        pin(1'b1, 1'b0, 1'b0);
        pin(1'b0, 1'b0, 1'b0);
        clk_bit(1'b1); clk_bit(1'b1); clk_bit(1'b1); clk_bit(1'b0);
        ana[1] = 8'hC3;
        repeat (FULL) clk_bit(1'b0);
        pin(1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) ana[i] = AW'($urandom);
            conv(1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FULL)) : FULL,
                 int'($urandom_range(0, 2)));
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
